// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer: steps Fetch..Write Back, decodes datapath enables from the
// current stage, and bounds the memory-write handshake with a timeout.
module stage_sequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned NOP_SKIP = 1
) (
    input  logic             Clock,
    input  logic             Reset_L,
    input  logic             Run,
    input  logic             Stall,
    input  logic             NOP_FLAG,
    input  logic             WillWriteTo_Memory_H_RF_L,
    input  logic             Mem_Ready,
    output logic [2:0]       Stage,
    output logic             IR_Enable,
    output logic             PC_Enable,
    output logic             RA_Enable,
    output logic             RB_Enable,
    output logic             RZ_Enable,
    output logic             RM_Enable,
    output logic             RY_Enable,
    output logic             MEM_Read,
    output logic             MEM_Write,
    output logic             RF_WRITE,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Instr_Count
);

    localparam int unsigned WaitW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMemory    = 3'd4,
        StWriteBack = 3'd5
    } stage_e;

    stage_e             stage_q, stage_d;
    logic               nop_q, nop_d;
    logic               wr_q, wr_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               retire;
    logic               mem_wr_pending;

    // Stage 4 owns a real RAM write only for non-NOP memory-destination instructions.
    assign mem_wr_pending = (stage_q == StMemory) && wr_q && !nop_q;

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            stage_q   <= StIdle;
            nop_q     <= 1'b0;
            wr_q      <= 1'b0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            stage_q   <= stage_d;
            nop_q     <= nop_d;
            wr_q      <= wr_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        stage_d   = stage_q;
        nop_d     = nop_q;
        wr_d      = wr_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        retire    = 1'b0;
        // Stall freezes everything, including the write-wait counter.
        if (!Stall) begin
            unique case (stage_q)
                StIdle: begin
                    if (Run) stage_d = StFetch;
                end
                StFetch: begin
                    stage_d = StDecode;
                end
                StDecode: begin
                    nop_d = NOP_FLAG;
                    wr_d  = WillWriteTo_Memory_H_RF_L;
                    if ((NOP_SKIP != 0) && NOP_FLAG) begin
                        stage_d = Run ? StFetch : StIdle;
                        retire  = 1'b1;
                    end else begin
                        stage_d = StExecute;
                    end
                end
                StExecute: begin
                    stage_d = StMemory;
                end
                StMemory: begin
                    if (!mem_wr_pending || Mem_Ready) begin
                        stage_d = StWriteBack;
                        wait_d  = '0;
                    end else if (wait_q == WaitW'(WAIT_MAX)) begin
                        stage_d   = StWriteBack;
                        timeout_d = 1'b1;
                        wait_d    = '0;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end
                StWriteBack: begin
                    stage_d = Run ? StFetch : StIdle;
                    retire  = 1'b1;
                end
                default: begin
                    stage_d = StIdle;
                end
            endcase
        end
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    always_comb begin
        IR_Enable = 1'b0;
        PC_Enable = 1'b0;
        RA_Enable = 1'b0;
        RB_Enable = 1'b0;
        RZ_Enable = 1'b0;
        RM_Enable = 1'b0;
        RY_Enable = 1'b0;
        MEM_Read  = 1'b0;
        MEM_Write = 1'b0;
        RF_WRITE  = 1'b0;
        if (!Stall) begin
            unique case (stage_q)
                StFetch: begin
                    IR_Enable = 1'b1;
                    PC_Enable = 1'b1;
                    MEM_Read  = 1'b1;
                end
                StDecode: begin
                    // The NOP flag is live here; it is only latched at the end of this stage.
                    RA_Enable = !NOP_FLAG;
                    RB_Enable = !NOP_FLAG;
                end
                StExecute: begin
                    RZ_Enable = !nop_q;
                    RM_Enable = !nop_q;
                end
                StMemory: begin
                    RY_Enable = !nop_q;
                    MEM_Write = wr_q && !nop_q;
                end
                StWriteBack: begin
                    RF_WRITE = !wr_q && !nop_q;
                end
                default: ;
            endcase
        end
    end

    assign Stage       = stage_q;
    assign Mem_Timeout = timeout_q;
    assign Instr_Count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default build plus a NOP_SKIP=0, CNT_W=2 build.
module tb_stage_sequencer;

    logic Clock;
    logic rst_n, run, stall, nop, wr, mrdy;
    logic rst2_n, run2, nop2, wr2;

    logic [2:0]  st1, st2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;
    logic        tmo1, tmo2;
    logic        ir1, pc1, ra1, rb1, rz1, rm1, ry1, mr1, mw1, rf1;
    logic        ir2, pc2, ra2, rb2, rz2, rm2, ry2, mr2, mw2, rf2;
    logic [9:0]  en1, en2;

    int n_checks = 0;
    int n_fail   = 0;

    assign en1 = {ir1, pc1, ra1, rb1, rz1, rm1, ry1, mr1, mw1, rf1};
    assign en2 = {ir2, pc2, ra2, rb2, rz2, rm2, ry2, mr2, mw2, rf2};

    stage_sequencer dut (
        .Clock(Clock), .Reset_L(rst_n), .Run(run), .Stall(stall), .NOP_FLAG(nop),
        .WillWriteTo_Memory_H_RF_L(wr), .Mem_Ready(mrdy), .Stage(st1),
        .IR_Enable(ir1), .PC_Enable(pc1), .RA_Enable(ra1), .RB_Enable(rb1),
        .RZ_Enable(rz1), .RM_Enable(rm1), .RY_Enable(ry1), .MEM_Read(mr1),
        .MEM_Write(mw1), .RF_WRITE(rf1), .Mem_Timeout(tmo1), .Instr_Count(cnt1)
    );

    stage_sequencer #(.CNT_W(2), .WAIT_MAX(3), .NOP_SKIP(0)) dut2 (
        .Clock(Clock), .Reset_L(rst2_n), .Run(run2), .Stall(stall), .NOP_FLAG(nop2),
        .WillWriteTo_Memory_H_RF_L(wr2), .Mem_Ready(mrdy), .Stage(st2),
        .IR_Enable(ir2), .PC_Enable(pc2), .RA_Enable(ra2), .RB_Enable(rb2),
        .RZ_Enable(rz2), .RM_Enable(rm2), .RY_Enable(ry2), .MEM_Read(mr2),
        .MEM_Write(mw2), .RF_WRITE(rf2), .Mem_Timeout(tmo2), .Instr_Count(cnt2)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within 200000 time units");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp1(input string tag, input int st, input int en);
        check_eq({tag, "/stage"}, 32'(st1), st);
        check_eq({tag, "/en"}, 32'(en1), en);
    endtask

    task automatic exp2(input string tag, input int st, input int en);
        check_eq({tag, "/stage"}, 32'(st2), st);
        check_eq({tag, "/en"}, 32'(en2), en);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Enable vector order: IR PC RA RB RZ RM RY MR MW RF
    localparam int EnFetch = 'h304;
    localparam int EnDec   = 'h0C0;
    localparam int EnExe   = 'h030;
    localparam int EnMem   = 'h008;
    localparam int EnMemWr = 'h00A;
    localparam int EnWb    = 'h001;

    initial begin
        int n;
        int pc_hi;
        rst_n = 1'b0; rst2_n = 1'b0;
        run = 1'b0; stall = 1'b0; nop = 1'b0; wr = 1'b0; mrdy = 1'b0;
        run2 = 1'b0; nop2 = 1'b0; wr2 = 1'b0;

        #2;
        exp1("reset", 0, 0);
        check_eq("reset/count", 32'(cnt1), 0);
        check_eq("reset/timeout", 32'(tmo1), 0);
        exp2("reset2", 0, 0);
        #10;
        rst_n = 1'b1; rst2_n = 1'b1;

        tick();
        exp1("idle_hold", 0, 0);

        // Register-file op, then straight into the next fetch.
        run = 1'b1;
        tick(); exp1("rf/s1", 1, EnFetch);
        tick(); exp1("rf/s2", 2, EnDec);
        tick(); exp1("rf/s3", 3, EnExe);
        tick(); exp1("rf/s4", 4, EnMem);
        tick(); exp1("rf/s5", 5, EnWb);
        check_eq("rf/count_before", 32'(cnt1), 0);
        tick(); exp1("rf/next", 1, EnFetch);
        check_eq("rf/count", 32'(cnt1), 1);

        // Memory write, Mem_Ready low for three stage-4 cycles.
        wr = 1'b1;
        tick(); exp1("mw/s2", 2, EnDec);
        tick(); exp1("mw/s3", 3, EnExe);
        tick();
        for (int i = 0; i < 4; i++) begin
            exp1($sformatf("mw/s4_%0d", i), 4, EnMemWr);
            mrdy = (i == 3);
            tick();
        end
        exp1("mw/s5", 5, 0);
        check_eq("mw/timeout", 32'(tmo1), 0);
        run = 1'b0;
        tick(); exp1("mw/idle", 0, 0);
        check_eq("mw/count", 32'(cnt1), 2);

        // Mem_Ready never arrives: timeout after 16 stage-4 cycles.
        mrdy = 1'b0; run = 1'b1;
        tick(); tick(); tick(); tick();
        exp1("to/s4", 4, EnMemWr);
        n = 1;
        for (int g = 0; g < 40; g++) begin
            tick();
            if (st1 != 3'd4) break;
            n++;
        end
        check_eq("to/s4_cycles", 32'(n), 16);
        exp1("to/s5", 5, 0);
        check_eq("to/flag", 32'(tmo1), 1);
        run = 1'b0;
        tick(); exp1("to/idle", 0, 0);
        check_eq("to/count", 32'(cnt1), 3);
        tick();
        check_eq("to/sticky", 32'(tmo1), 1);

        // NOP skip: 1,2,1 with Run=1, then 1,2,IDLE with Run=0.
        run = 1'b1; nop = 1'b1; wr = 1'b0; mrdy = 1'b1;
        tick(); exp1("nop/s1", 1, EnFetch);
        tick(); exp1("nop/s2", 2, 0);
        tick(); exp1("nop/back", 1, EnFetch);
        check_eq("nop/count", 32'(cnt1), 4);
        run = 1'b0;
        tick(); exp1("nop/s2b", 2, 0);
        tick(); exp1("nop/idle", 0, 0);
        check_eq("nop/count2", 32'(cnt1), 5);

        // Stall two cycles in Fetch.
        run = 1'b1; nop = 1'b0;
        pc_hi = 0;
        tick(); stall = 1'b1; #1;
        exp1("stall/a", 1, 0);
        pc_hi += int'(pc1);
        tick();
        exp1("stall/b", 1, 0);
        pc_hi += int'(pc1);
        tick(); stall = 1'b0; #1;
        exp1("stall/c", 1, EnFetch);
        pc_hi += int'(pc1);
        check_eq("stall/pc_cycles", 32'(pc_hi), 1);
        run = 1'b0;
        tick(); exp1("stall/s2", 2, EnDec);
        tick(); tick(); tick();
        exp1("stall/s5", 5, EnWb);
        tick(); exp1("stall/idle", 0, 0);
        check_eq("stall/count", 32'(cnt1), 6);

        // NOP_SKIP=0: NOPs walk all stages with datapath enables off; 2-bit count wraps.
        run2 = 1'b1; nop2 = 1'b1; wr2 = 1'b0;
        tick(); exp2("walk/s1", 1, EnFetch);
        for (int r = 1; r <= 5; r++) begin
            for (int s = 2; s <= 5; s++) begin
                tick(); exp2($sformatf("walk%0d/s%0d", r, s), s, 0);
            end
            tick(); exp2($sformatf("walk%0d/s1", r), 1, EnFetch);
            check_eq($sformatf("walk%0d/count", r), 32'(cnt2), r % 4);
        end

        // Reset pulse in Execute abandons the instruction.
        nop2 = 1'b0; wr2 = 1'b1;
        tick(); exp2("rst/s2", 2, EnDec);
        tick(); exp2("rst/s3", 3, EnExe);
        #2; rst2_n = 1'b0; #1;
        exp2("rst/async", 0, 0);
        check_eq("rst/count", 32'(cnt2), 0);
        check_eq("rst/timeout", 32'(tmo2), 0);
        #2; rst2_n = 1'b1; run2 = 1'b0;
        tick(); exp2("rst/idle", 0, 0);
        run2 = 1'b1;
        tick(); exp2("rst/restart", 1, EnFetch);
        run2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
